wb_regfile: RTL and testbench

- Writeback stage plus integer register file for the 5-stage RV32I pipeline.
- Consumes the W-stage outputs of the MEM/WB pipeline register and selects the writeback result.
- Commits that result into the 32x32 architectural register file.
- Serves the two Decode-stage read ports, with same-cycle write-through bypass so a D-stage read sees the value being written back that cycle.

---
 rtl/wb_regfile.sv | 99 +++++++++
 tb/tb_wb_regfile.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: RV32I writeback stage and 32x32 integer register file.
// Selects the writeback result, commits it to the architectural register
// file, and serves two zero-latency Decode read ports. When the W stage
// writes a register that Decode reads in the same cycle, the read port
// returns the value being written.
// Optional feature: define WB_REGFILE_RETIRE_CNT_EN to add the 64-bit
// RetireCnt output, which counts committed register writes (x0 excluded).
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [4:0]      RdW,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
`ifdef WB_REGFILE_RETIRE_CNT_EN
  output logic [63:0]     RetireCnt,
`endif
  output logic [XLEN-1:0] ResultW
);

  // Architectural state. Entry 0 is cleared by reset and is never written,
  // but the read path returns 0 for x0 without consulting the array anyway.
  logic [XLEN-1:0] regs_reg [NREG];

  // A write commits only when enabled and aimed at a real register.
  logic commit;
  assign commit = RegWriteW && (RdW != 5'd0);

  // Writeback select; code 11 yields zero so the result is always defined.
  always_comb begin
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

  // Register array update; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (commit) begin
      regs_reg[RdW] <= ResultW;
    end
  end

  // Read port 1: reset forces 0, x0 reads 0, same-cycle write bypasses.
  always_comb begin
    RD1D = '0;
    if (reset || (Rs1D == 5'd0)) begin
      RD1D = '0;
    end else if (RegWriteW && (RdW == Rs1D)) begin
      RD1D = ResultW;
    end else begin
      RD1D = regs_reg[Rs1D];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    RD2D = '0;
    if (reset || (Rs2D == 5'd0)) begin
      RD2D = '0;
    end else if (RegWriteW && (RdW == Rs2D)) begin
      RD2D = ResultW;
    end else begin
      RD2D = regs_reg[Rs2D];
    end
  end

`ifdef WB_REGFILE_RETIRE_CNT_EN
  logic [63:0] retire_cnt_reg;

  // Count committed writes; x0 writes and reset-cycle writes do not retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_reg <= '0;
    end else if (commit) begin
      retire_cnt_reg <= retire_cnt_reg + 64'd1;
    end
  end

  assign RetireCnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed plus randomized checks of wb_regfile against a
// behavioural model (array of register values and a retire count).
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;
`ifdef WB_REGFILE_RETIRE_CNT_EN
  logic [63:0] RetireCnt;
`endif

  wb_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWriteW (RegWriteW),
    .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW),
    .ReadDataW (ReadDataW),
    .PCPlus4W  (PCPlus4W),
    .RdW       (RdW),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .RD1D      (RD1D),
    .RD2D      (RD2D),
`ifdef WB_REGFILE_RETIRE_CNT_EN
    .RetireCnt (RetireCnt),
`endif
    .ResultW   (ResultW)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0]     model_regs [32];
  longint unsigned model_cnt = 0;

  function automatic logic [31:0] exp_result();
    case (ResultSrcW)
      2'b00:   return ALUResultW;
      2'b01:   return ReadDataW;
      2'b10:   return PCPlus4W;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] rs);
    if (reset || rs == 5'd0) return 32'd0;
    if (RegWriteW && RdW == rs) return exp_result();
    return model_regs[rs];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Check all combinational outputs for the currently driven inputs.
  task automatic check_comb(input string tag);
    #1;
    check({tag, ".ResultW"}, {32'd0, ResultW}, {32'd0, exp_result()});
    check({tag, ".RD1D"}, {32'd0, RD1D}, {32'd0, exp_read(Rs1D)});
    check({tag, ".RD2D"}, {32'd0, RD2D}, {32'd0, exp_read(Rs2D)});
  endtask

  // Advance one clock and apply the commit rules to the model.
  task automatic tick();
    logic [31:0] r;
    r = exp_result();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_cnt = 0;
    end else if (RegWriteW && RdW != 5'd0) begin
      model_regs[RdW] = r;
      model_cnt++;
    end
    #1;
`ifdef WB_REGFILE_RETIRE_CNT_EN
    check("RetireCnt", RetireCnt, model_cnt);
`endif
  endtask

  task automatic drive(input logic rst, input logic we, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] pc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    reset = rst; RegWriteW = we; ResultSrcW = src; ALUResultW = alu;
    ReadDataW = rdat; PCPlus4W = pc; RdW = rd; Rs1D = rs1; Rs2D = rs2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    // Reset for one cycle; reads forced to 0 while reset is high.
    drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    check_comb("reset_hold");
    tick();

    // After reset every register reads 0.
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    check_comb("post_reset");
    for (int i = 0; i < 32; i++) begin
      Rs1D = 5'(i); Rs2D = 5'(31 - i);
      #1;
      check("sweep.RD1D", {32'd0, RD1D}, 64'd0);
      check("sweep.RD2D", {32'd0, RD2D}, 64'd0);
    end

    // Bypass on write to x3, then read back from the array.
    drive(1'b0, 1'b1, 2'b00, 32'h0000_1234, 32'd0, 32'd0, 5'd3, 5'd3, 5'd3);
    check_comb("bypass_x3");
    check("bypass_x3.lit", {32'd0, RD1D}, 64'h1234);
    tick();
    RegWriteW = 1'b0;
    check_comb("array_x3");
    check("array_x3.lit", {32'd0, RD1D}, 64'h1234);

    // Each writeback source into x7.
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 2'(c), 32'hA, 32'hB, 32'hC, 5'd7, 5'd7, 5'd0);
      check_comb("src_sel");
      tick();
      RegWriteW = 1'b0;
      check_comb("src_sel_rb");
      check("src_sel.lit", {32'd0, RD1D}, (c == 3) ? 64'd0 : 64'hA + 64'(c));
    end

    // Write to x0 is discarded and x0 always reads 0.
    drive(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    check_comb("x0_write");
    check("x0_write.ResultW", {32'd0, ResultW}, 64'hFFFF_FFFF);
    tick();
    RegWriteW = 1'b0;
    check_comb("x0_after");

    // Reset beats a simultaneous write.
    drive(1'b0, 1'b1, 2'b00, 32'h55, 32'd0, 32'd0, 5'd10, 5'd10, 5'd10);
    tick();
    drive(1'b1, 1'b1, 2'b00, 32'h99, 32'd0, 32'd0, 5'd10, 5'd10, 5'd10);
    check_comb("reset_vs_write");
    check("reset_vs_write.lit", {32'd0, RD1D}, 64'd0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd10, 5'd3);
    check_comb("after_reset_x10");
    check("after_reset_x10.lit", {32'd0, RD1D}, 64'd0);

`ifdef WB_REGFILE_RETIRE_CNT_EN
    // 5 real writes, 2 to x0, 3 idle cycles -> count of 5, then reset.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, (k < 7), 2'b00, 32'(k), 32'd0, 32'd0,
            (k < 5) ? 5'(k + 1) : 5'd0, 5'd1, 5'd2);
      tick();
    end
    check("retire_five", RetireCnt, 64'd5);
    reset = 1'b1;
    tick();
    check("retire_reset", RetireCnt, 64'd0);
    reset = 1'b0;
`endif

    // Randomized traffic with occasional reset and biased index collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, rd,
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom),
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom));
      check_comb("random");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
